// File: rtl/seq_detect_pkg.sv
// Shared types and constants for the 1100 detector test sequencer.
// Holds the FSM state encoding and the active-low hex digit table.
package seq_detect_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_STEP,
        S_SAMPLE,
        S_DONE
    } state_e;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Segment order {dp,g,f,e,d,c,b,a}, active-low
    function automatic logic [7:0] hex_to_seg(input logic [3:0] v);
        logic [7:0] s;
        s = SEG_BLANK;
        case (v)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            4'hF: s = 8'h8E;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seq_prescaler.sv
// Bit-period divider: counts 0..DIV-1 while enabled by an idle clear.
// tc_o flags the last cycle of the period.
module seq_prescaler #(
    parameter int unsigned DIV = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    output logic tc_o
);

    localparam logic [7:0] LAST = 8'(DIV - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    assign tc_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 8'd1;
        if (clr_i || tc_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seq_detect_sequencer.sv
// Feeds a latched byte MSB-first into the 1100 detector and counts hits.
// All outputs are registered from the next-state values.
module seq_detect_sequencer
    import seq_detect_pkg::*;
#(
    parameter int unsigned DIV = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic [7:0] data_i,
    input  logic       det_y_i,
    input  logic [7:0] det_literal_i,
    output logic       x_out_o,
    output logic       det_step_o,
    output logic       det_rst_n_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [3:0] hits_o,
    output logic [7:0] seg_o
);

    state_e     state_q, state_d;
    logic [7:0] shreg_q, shreg_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] hits_q, hits_d;
    logic       x_q, step_q, clr_n_q, busy_q, done_q;
    logic [7:0] seg_q;
    logic       tc;
    logic       run_d;

    seq_prescaler #(.DIV(DIV)) u_presc (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .clr_i (state_q != S_WAIT),
        .tc_o  (tc)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        hits_d    = hits_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d   = S_LOAD;
                    shreg_d   = data_i;
                    bit_cnt_d = '0;
                    hits_d    = '0;
                end
            end
            S_LOAD: state_d = S_WAIT;
            S_WAIT: begin
                if (tc) state_d = S_STEP;
            end
            S_STEP: state_d = S_SAMPLE;
            S_SAMPLE: begin
                if (det_y_i && hits_q != 4'hF) begin
                    hits_d = hits_q + 4'd1;
                end
                shreg_d   = {shreg_q[6:0], 1'b0};
                bit_cnt_d = bit_cnt_q + 3'd1;
                state_d   = (bit_cnt_q == 3'd7) ? S_DONE : S_WAIT;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Detector is live only while bits are being shifted out
    assign run_d = (state_d == S_WAIT) || (state_d == S_STEP) ||
                   (state_d == S_SAMPLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            hits_q    <= '0;
            x_q       <= 1'b0;
            step_q    <= 1'b0;
            clr_n_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            seg_q     <= hex_to_seg(4'h0);
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            hits_q    <= hits_d;
            x_q       <= run_d & shreg_d[7];
            step_q    <= (state_d == S_STEP);
            clr_n_q   <= (state_d != S_LOAD);
            busy_q    <= (state_d != S_IDLE);
            done_q    <= (state_d == S_DONE);
            seg_q     <= run_d ? det_literal_i : hex_to_seg(hits_d);
        end
    end

    assign x_out_o     = x_q;
    assign det_step_o  = step_q;
    assign det_rst_n_o = clr_n_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign hits_o      = hits_q;
    assign seg_o       = seg_q;

endmodule

// File: tb/tb_seq_detect_sequencer.sv
// Directed bench: DIV=4 unit drives a reference 1100 detector,
// DIV=1 unit sees a detector output stuck at 1.
module tb_seq_detect_sequencer;

    logic       clk;
    logic       rst_n;
    logic [7:0] data;
    logic       start_w [2];
    logic       x_w     [2];
    logic       step_w  [2];
    logic       clrn_w  [2];
    logic       busy_w  [2];
    logic       done_w  [2];
    logic [3:0] hits_w  [2];
    logic [7:0] seg_w   [2];

    logic [2:0] st;
    logic       det_y;
    logic [7:0] det_lit;

    int npass;
    int nchk;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    seq_detect_sequencer #(.DIV(4)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start_w[0]),
        .data_i       (data),
        .det_y_i      (det_y),
        .det_literal_i(det_lit),
        .x_out_o      (x_w[0]),
        .det_step_o   (step_w[0]),
        .det_rst_n_o  (clrn_w[0]),
        .busy_o       (busy_w[0]),
        .done_o       (done_w[0]),
        .hits_o       (hits_w[0]),
        .seg_o        (seg_w[0])
    );

    seq_detect_sequencer #(.DIV(1)) dut1 (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start_w[1]),
        .data_i       (data),
        .det_y_i      (1'b1),
        .det_literal_i(8'h00),
        .x_out_o      (x_w[1]),
        .det_step_o   (step_w[1]),
        .det_rst_n_o  (clrn_w[1]),
        .busy_o       (busy_w[1]),
        .done_o       (done_w[1]),
        .hits_o       (hits_w[1]),
        .seg_o        (seg_w[1])
    );

    // Reference overlapping 1100 Moore detector; state 4 = found
    function automatic logic [2:0] det_nxt(input logic [2:0] s, input logic x);
        case (s)
            3'd0: det_nxt = x ? 3'd1 : 3'd0;
            3'd1: det_nxt = x ? 3'd2 : 3'd0;
            3'd2: det_nxt = x ? 3'd2 : 3'd3;
            3'd3: det_nxt = x ? 3'd1 : 3'd4;
            default: det_nxt = x ? 3'd1 : 3'd0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n || !clrn_w[0]) begin
            st <= 3'd0;
        end else if (step_w[0]) begin
            st <= det_nxt(st, x_w[0]);
        end
    end

    assign det_y   = (st == 3'd4);
    assign det_lit = {5'b10101, st};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic run(input int k, input logic [7:0] d, input int exp_done,
                       input logic [3:0] exp_hits, input logic [7:0] exp_seg,
                       input int inj);
        int n, steps, clrs, done_at;
        logic [7:0] xs;
        data = d;
        start_w[k] = 1'b1;
        @(negedge clk);
        start_w[k] = 1'b0;
        n = 1; steps = 0; clrs = 0; done_at = 0; xs = '0;
        chk("load_busy", 32'(busy_w[k]), 32'd1);
        chk("load_clr", 32'(clrn_w[k]), 32'd0);
        while (done_at == 0 && n < 200) begin
            if (step_w[k]) begin
                steps++;
                xs = {xs[6:0], x_w[k]};
            end
            if (!clrn_w[k]) clrs++;
            if (k == 0 && n == 3) chk("wait_seg", 32'(seg_w[0]), 32'hA8);
            if (done_w[k]) begin
                done_at = n;
            end else begin
                start_w[k] = (inj != 0 && n == inj);
                @(negedge clk);
                start_w[k] = 1'b0;
                n++;
            end
        end
        chk("done_cycle", 32'(done_at), 32'(exp_done));
        chk("step_count", 32'(steps), 32'd8);
        chk("clr_pulses", 32'(clrs), 32'd1);
        chk("serial_x", 32'(xs), 32'(d));
        chk("hits", 32'(hits_w[k]), 32'(exp_hits));
        chk("seg_done", 32'(seg_w[k]), 32'(exp_seg));
        @(negedge clk);
        chk("busy_low", 32'(busy_w[k]), 32'd0);
    endtask

    initial begin
        int n;
        npass = 0;
        nchk  = 0;
        rst_n = 1'b0;
        data  = '0;
        start_w[0] = 1'b0;
        start_w[1] = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_x", 32'(x_w[0]), 32'd0);
        chk("rst_step", 32'(step_w[0]), 32'd0);
        chk("rst_clrn", 32'(clrn_w[0]), 32'd1);
        chk("rst_busy", 32'(busy_w[0]), 32'd0);
        chk("rst_done", 32'(done_w[0]), 32'd0);
        chk("rst_hits", 32'(hits_w[0]), 32'd0);
        chk("rst_seg", 32'(seg_w[0]), 32'hC0);
        rst_n = 1'b1;
        @(negedge clk);

        run(0, 8'b1100_1100, 50, 4'd2, 8'hA4, 0);
        run(0, 8'b1111_0000, 50, 4'd1, 8'hF9, 0);
        run(0, 8'h00,        50, 4'd0, 8'hC0, 0);
        run(0, 8'b1100_0110, 50, 4'd1, 8'hF9, 0);
        run(0, 8'b1100_1100, 50, 4'd2, 8'hA4, 20);

        // Start held high: ignored in DONE, retriggers from IDLE
        data = 8'h00;
        start_w[0] = 1'b1;
        n = 0;
        while (!done_w[0] && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("held_done", 32'(n), 32'd50);
        @(negedge clk);
        chk("held_idle_busy", 32'(busy_w[0]), 32'd0);
        @(negedge clk);
        chk("held_retrig_busy", 32'(busy_w[0]), 32'd1);
        chk("held_retrig_clr", 32'(clrn_w[0]), 32'd0);
        start_w[0] = 1'b0;
        n = 0;
        while (!done_w[0] && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("held_second_done", 32'(done_w[0]), 32'd1);
        @(negedge clk);

        // Reset in the STEP cycle of bit 5
        data = 8'b1100_1100;
        start_w[0] = 1'b1;
        @(negedge clk);
        start_w[0] = 1'b0;
        repeat (35) @(negedge clk);
        chk("pre_rst_step", 32'(step_w[0]), 32'd1);
        chk("pre_rst_hits", 32'(hits_w[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_x", 32'(x_w[0]), 32'd0);
        chk("mid_rst_step", 32'(step_w[0]), 32'd0);
        chk("mid_rst_clrn", 32'(clrn_w[0]), 32'd1);
        chk("mid_rst_busy", 32'(busy_w[0]), 32'd0);
        chk("mid_rst_done", 32'(done_w[0]), 32'd0);
        chk("mid_rst_hits", 32'(hits_w[0]), 32'd0);
        chk("mid_rst_seg", 32'(seg_w[0]), 32'hC0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run(0, 8'b1111_0000, 50, 4'd1, 8'hF9, 0);

        // Stuck-at-1 detector, DIV=1: hits clear per run
        run(1, 8'hA5, 26, 4'd8, 8'h80, 0);
        run(1, 8'h3C, 26, 4'd8, 8'h80, 0);

        // Hold the bit count at zero to push hits past 15
        data = 8'h3C;
        start_w[1] = 1'b1;
        @(negedge clk);
        start_w[1] = 1'b0;
        repeat (2) @(negedge clk);
        force dut1.bit_cnt_q = 3'd0;
        repeat (30) @(negedge clk);
        release dut1.bit_cnt_q;
        n = 0;
        while (!done_w[1] && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("sat_done", 32'(done_w[1]), 32'd1);
        chk("sat_hits", 32'(hits_w[1]), 32'd15);
        chk("sat_seg", 32'(seg_w[1]), 32'h8E);
        @(negedge clk);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
